// File: rtl/aibcr3_dll_codereg_mc_if.sv
// Bundle of scan, control and code signals between the DLL lock state machines
// and the multi-channel delay-code register.
interface aibcr3_dll_codereg_mc_if #(
    parameter int NCH     = 2,
    parameter int GREY_W  = 7,
    parameter int IGRAY_W = 3
);
    logic                     SE;
    logic                     SI;
    logic                     SO_OUT;
    logic                     capture_mode;
    logic                     freeze;
    logic                     ovr_en;
    logic [GREY_W-1:0]        ovr_grey;
    logic [IGRAY_W-1:0]       ovr_igray;
    logic [NCH-1:0]           code_valid;
    logic [NCH*GREY_W-1:0]    sm_grey;
    logic [NCH*IGRAY_W-1:0]   sm_igray;
    logic [NCH*GREY_W-1:0]    grey;
    logic [NCH*IGRAY_W-1:0]   igray;
    logic [NCH-1:0]           valid_sync;
    logic [NCH-1:0]           upd_pulse;

    modport master (
        output SE, SI, capture_mode, freeze, ovr_en, ovr_grey, ovr_igray,
               code_valid, sm_grey, sm_igray,
        input  SO_OUT, grey, igray, valid_sync, upd_pulse
    );

    modport slave (
        input  SE, SI, capture_mode, freeze, ovr_en, ovr_grey, ovr_igray,
               code_valid, sm_grey, sm_igray,
        output SO_OUT, grey, igray, valid_sync, upd_pulse
    );
endinterface

// File: rtl/aibcr3_dll_codereg_mc.sv
// Multi-channel DLL delay-code holding register: every state flop lives in one
// flat scan vector, with per-channel fields carved out of it by fixed offsets.
module aibcr3_dll_codereg_mc #(
    parameter int NCH         = 2,
    parameter int GREY_W      = 7,
    parameter int IGRAY_W     = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CK,
    input  logic                  RST,
    aibcr3_dll_codereg_mc_if.slave bus
);
    // Per-channel layout: sync[0..S-1], vq, grey[0..G-1], igray[0..I-1]
    localparam int OFS_VQ  = SYNC_STAGES;
    localparam int OFS_G   = SYNC_STAGES + 1;
    localparam int OFS_I   = SYNC_STAGES + 1 + GREY_W;
    localparam int CW      = SYNC_STAGES + 1 + GREY_W + IGRAY_W;
    localparam int CHAIN_W = NCH * CW;

    logic [CHAIN_W-1:0] chain_q, chain_d;
    logic [NCH-1:0]     chg_q, chg_d;
    logic [NCH-1:0]     upd_q, upd_d;
    logic [NCH-1:0]     ld_s;

    // Next state: scan shift, or synchroniser advance plus code load/hold per channel
    always_comb begin
        chain_d = chain_q;
        chg_d   = '0;
        upd_d   = '0;
        ld_s    = '0;
        if (bus.SE) begin
            chain_d = {chain_q[CHAIN_W-2:0], bus.SI};
        end else begin
            upd_d = chg_q;
            for (int c = 0; c < NCH; c++) begin
                chain_d[c*CW] = bus.code_valid[c];
                for (int k = 1; k < SYNC_STAGES; k++) begin
                    chain_d[c*CW+k] = chain_q[c*CW+k-1];
                end
                chain_d[c*CW+OFS_VQ] = chain_q[c*CW+SYNC_STAGES-1];
                // Capture mode only loads on the synchronised valid's rising edge
                if (bus.capture_mode) begin
                    ld_s[c] = chain_q[c*CW+SYNC_STAGES-1] & ~chain_q[c*CW+OFS_VQ];
                end else begin
                    ld_s[c] = chain_q[c*CW+SYNC_STAGES-1];
                end
                if (bus.freeze) begin
                    chain_d[c*CW+OFS_G +: GREY_W+IGRAY_W] = chain_q[c*CW+OFS_G +: GREY_W+IGRAY_W];
                end else if (bus.ovr_en) begin
                    chain_d[c*CW+OFS_G +: GREY_W]  = bus.ovr_grey;
                    chain_d[c*CW+OFS_I +: IGRAY_W] = bus.ovr_igray;
                end else if (ld_s[c]) begin
                    chain_d[c*CW+OFS_G +: GREY_W]  = bus.sm_grey[c*GREY_W +: GREY_W];
                    chain_d[c*CW+OFS_I +: IGRAY_W] = bus.sm_igray[c*IGRAY_W +: IGRAY_W];
                end else begin
                    chain_d[c*CW+OFS_G +: GREY_W+IGRAY_W] = chain_q[c*CW+OFS_G +: GREY_W+IGRAY_W];
                end
                chg_d[c] = (chain_d[c*CW+OFS_G +: GREY_W+IGRAY_W] !=
                            chain_q[c*CW+OFS_G +: GREY_W+IGRAY_W]);
            end
        end
    end

    // State registers; the change flag is staged once more before becoming the pulse
    always_ff @(posedge CK) begin
        if (RST) begin
            chain_q <= '0;
            chg_q   <= '0;
            upd_q   <= '0;
        end else begin
            chain_q <= chain_d;
            chg_q   <= chg_d;
            upd_q   <= upd_d;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_out
        assign bus.grey[c*GREY_W +: GREY_W]    = chain_q[c*CW+OFS_G +: GREY_W];
        assign bus.igray[c*IGRAY_W +: IGRAY_W] = chain_q[c*CW+OFS_I +: IGRAY_W];
        assign bus.valid_sync[c]               = chain_q[c*CW+SYNC_STAGES-1];
    end

    assign bus.upd_pulse = upd_q;
    assign bus.SO_OUT    = chain_q[CHAIN_W-1];
endmodule

// File: tb/tb_aibcr3_dll_codereg_mc.sv
// Directed bench for the DLL code register: reset, track latency, capture,
// override/freeze, scan chain and reset during shift/capture.
module tb_aibcr3_dll_codereg_mc;
    logic CK;
    logic RST;
    int   checks;
    int   failures;
    logic [25:0] pat;

    aibcr3_dll_codereg_mc_if #(.NCH(2), .GREY_W(7), .IGRAY_W(3)) bus ();

    aibcr3_dll_codereg_mc #(
        .NCH(2), .GREY_W(7), .IGRAY_W(3), .SYNC_STAGES(2)
    ) dut (
        .CK (CK),
        .RST(RST),
        .bus(bus.slave)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        pat      = 26'h2AAAAAA;
        RST = 1'b1;
        bus.SE = 1'b0; bus.SI = 1'b0; bus.capture_mode = 1'b0; bus.freeze = 1'b0;
        bus.ovr_en = 1'b0; bus.ovr_grey = 7'h00; bus.ovr_igray = 3'h0;
        bus.code_valid = 2'b11; bus.sm_grey = 14'h1234; bus.sm_igray = 6'h2D;

        // Reset
        step();
        check("rst_grey",  32'(bus.grey),       32'h0);
        check("rst_igray", 32'(bus.igray),      32'h0);
        check("rst_vsync", 32'(bus.valid_sync), 32'h0);
        check("rst_upd",   32'(bus.upd_pulse),  32'h0);
        check("rst_so",    32'(bus.SO_OUT),     32'h0);
        RST = 1'b0; bus.code_valid = 2'b00;
        step(); step(); step();
        check("idle_grey",  32'(bus.grey),  32'h0);
        check("idle_igray", 32'(bus.igray), 32'h0);

        // Track mode latency and follow
        bus.sm_grey = {7'h00, 7'h2A}; bus.sm_igray = {3'h0, 3'h5}; bus.code_valid = 2'b01;
        step();
        step();
        check("trk_vsync_e1", 32'(bus.valid_sync), 32'h1);
        check("trk_grey_e1",  32'(bus.grey),       32'h0);
        step();
        check("trk_grey_e2",  32'(bus.grey[6:0]),  32'h2A);
        check("trk_igray_e2", 32'(bus.igray[2:0]), 32'h5);
        check("trk_upd_e2",   32'(bus.upd_pulse),  32'h0);
        step();
        check("trk_upd_e3",   32'(bus.upd_pulse),  32'h1);
        step();
        check("trk_upd_e4",   32'(bus.upd_pulse),  32'h0);
        bus.sm_grey = {7'h00, 7'h2B};
        step();
        check("trk_follow",   32'(bus.grey[6:0]),  32'h2B);
        check("trk_upd_f0",   32'(bus.upd_pulse),  32'h0);
        step();
        check("trk_upd_f1",   32'(bus.upd_pulse),  32'h1);
        step();
        check("trk_upd_f2",   32'(bus.upd_pulse),  32'h0);

        // Capture mode on channel 1
        bus.capture_mode = 1'b1;
        bus.sm_grey = {7'h10, 7'h2B}; bus.sm_igray = {3'h3, 3'h5}; bus.code_valid = 2'b11;
        step(); step();
        check("cap_pre",     32'(bus.grey[13:7]), 32'h0);
        step();
        check("cap_load",    32'(bus.grey[13:7]), 32'h10);
        check("cap_load_ig", 32'(bus.igray[5:3]), 32'h3);
        bus.sm_grey[13:7] = 7'h11;
        step();
        check("cap_hold1",   32'(bus.grey[13:7]), 32'h10);
        bus.sm_grey[13:7] = 7'h12;
        step();
        check("cap_hold2",   32'(bus.grey[13:7]), 32'h10);
        check("cap_ch0",     32'(bus.grey[6:0]),  32'h2B);
        bus.code_valid = 2'b01;
        step(); step(); step();
        bus.sm_igray[5:3] = 3'h4; bus.code_valid = 2'b11;
        step(); step();
        check("cap_rearm",   32'(bus.grey[13:7]), 32'h10);
        step();
        check("cap_reload",  32'(bus.grey[13:7]), 32'h12);
        check("cap_rel_ig",  32'(bus.igray[5:3]), 32'h4);

        // Override then freeze
        bus.capture_mode = 1'b0; bus.ovr_en = 1'b1; bus.ovr_grey = 7'h7F; bus.ovr_igray = 3'h7;
        step();
        check("ovr_grey",  32'(bus.grey),      32'h3FFF);
        check("ovr_igray", 32'(bus.igray),     32'h3F);
        step();
        check("ovr_upd",   32'(bus.upd_pulse), 32'h3);
        step();
        check("ovr_upd2",  32'(bus.upd_pulse), 32'h0);
        bus.freeze = 1'b1; bus.ovr_grey = 7'h01; bus.ovr_igray = 3'h1;
        step();
        check("frz_grey",  32'(bus.grey),      32'h3FFF);
        check("frz_igray", 32'(bus.igray),     32'h3F);
        step();
        check("frz_upd",   32'(bus.upd_pulse), 32'h0);
        check("frz_grey2", 32'(bus.grey),      32'h3FFF);
        bus.ovr_en = 1'b0;

        // Scan shift-in, field decode, shift-out
        bus.SE = 1'b1;
        for (int i = 25; i >= 0; i--) begin
            bus.SI = pat[i];
            step();
            check("scan_upd_in", 32'(bus.upd_pulse), 32'h0);
        end
        check("scan_grey",  32'(bus.grey),       32'h1555);
        check("scan_igray", 32'(bus.igray),      32'h2A);
        check("scan_vsync", 32'(bus.valid_sync), 32'h1);
        for (int i = 25; i >= 0; i--) begin
            check("scan_so", 32'(bus.SO_OUT), 32'(pat[i]));
            bus.SI = 1'b0;
            step();
            check("scan_upd_out", 32'(bus.upd_pulse), 32'h0);
        end

        // Leave scan: no pulse for scanned-in contents
        for (int i = 25; i >= 0; i--) begin
            bus.SI = pat[i];
            step();
        end
        bus.SE = 1'b0; bus.code_valid = 2'b00;
        step();
        check("post_scan_upd0",  32'(bus.upd_pulse), 32'h0);
        check("post_scan_grey",  32'(bus.grey),      32'h1555);
        step();
        check("post_scan_upd1",  32'(bus.upd_pulse), 32'h0);
        check("post_scan_igray", 32'(bus.igray),     32'h2A);

        // Reset in the middle of a shift
        bus.SE = 1'b1; bus.SI = 1'b1;
        step(); step(); step();
        RST = 1'b1;
        step();
        check("rst_shift_grey",  32'(bus.grey),       32'h0);
        check("rst_shift_igray", 32'(bus.igray),      32'h0);
        check("rst_shift_vsync", 32'(bus.valid_sync), 32'h0);
        check("rst_shift_so",    32'(bus.SO_OUT),     32'h0);
        check("rst_shift_upd",   32'(bus.upd_pulse),  32'h0);

        // Reset in the middle of a capture
        RST = 1'b0; bus.SE = 1'b0; bus.SI = 1'b0; bus.freeze = 1'b0; bus.capture_mode = 1'b1;
        bus.sm_grey = {7'h12, 7'h2B}; bus.sm_igray = {3'h4, 3'h5}; bus.code_valid = 2'b11;
        step();
        RST = 1'b1;
        step();
        check("rst_cap_grey",  32'(bus.grey),       32'h0);
        check("rst_cap_vsync", 32'(bus.valid_sync), 32'h0);
        RST = 1'b0;
        step(); step();
        check("rst_cap_wait",  32'(bus.grey),       32'h0);
        step();
        check("rst_cap_grey2", 32'(bus.grey),       32'h092B);
        check("rst_cap_igray", 32'(bus.igray),      32'h25);
        step();
        check("rst_cap_upd",   32'(bus.upd_pulse),  32'h3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aibcr3_dll_codereg_mc.md
Name: aibcr3_dll_codereg_mc

Overview:
- Multi-channel, parametrised DLL delay-code holding register.
- Each channel registers a coarse grey code and a fine interpolator code from the DLL state machine. Loads are qualified by a per-channel code_valid, passed through a scan-visible synchroniser.
- Adds capture-on-edge mode, a broadcast override, a freeze hold and a per-channel update-pulse handshake.
- Every flop sits on one scan chain. The block sits between the DLL lock state machines and the delay-line decoders.

Parameters:
- NCH, 2, number of independent code channels.
- GREY_W, 7, coarse grey-code width per channel.
- IGRAY_W, 3, fine interpolator code width per channel.
- SYNC_STAGES, 2, code_valid synchroniser depth (>=2).

Ports:
- CK  in  1  sole clock, rising edge.
- RST  in  1  synchronous active-high reset.
- SE  in  1  scan enable; 1 = shift mode.
- SI  in  1  scan input.
- SO_OUT  out  1  scan output (last flop of chain).
- capture_mode  in  1  0 = track, 1 = capture on valid rising edge.
- freeze  in  1  hold all code registers.
- ovr_en  in  1  load override codes into all channels.
- ovr_grey  in  GREY_W  override coarse code.
- ovr_igray  in  IGRAY_W  override fine code.
- code_valid  in  NCH  per-channel async valid from the state machine.
- sm_grey  in  NCH*GREY_W  coarse codes; channel c at [c*GREY_W +: GREY_W].
- sm_igray  in  NCH*IGRAY_W  fine codes, packed the same way.
- grey  out  NCH*GREY_W  registered coarse codes.
- igray  out  NCH*IGRAY_W  registered fine codes.
- valid_sync  out  NCH  synchronised code_valid (last sync stage).
- upd_pulse  out  NCH  one-cycle pulse after a functional code change.

Behaviour:
- Clocking and reset: one clock, CK. RST is synchronous and active-high.
- Reset: RST=1 at a CK edge clears every flop, regardless of SE. After that edge, grey, igray, valid_sync, upd_pulse and SO_OUT are all 0.
- Per channel c, flops are sync[0..SYNC_STAGES-1], vq (sync[last] delayed one cycle), grey_c and igray_c.
- Priority at each edge: RST, then SE shift, then freeze, then ovr_en, then functional load.
- Scan shift (SE=1): every flop takes its chain predecessor.
  - Chain order: SI -> ch0 sync[0..S-1] -> ch0 vq -> ch0 grey[0..GREY_W-1] -> ch0 igray[0..IGRAY_W-1] -> ch1 ... -> SO_OUT.
  - Chain length is NCH*(SYNC_STAGES+1+GREY_W+IGRAY_W), which is 26 at the defaults.
  - upd_pulse is not in the chain; it is forced to 0 while SE=1.
- Functional mode (SE=0):
  - sync shifts code_valid[c] in every edge, including while freeze=1.
  - vq <= sync[last].
  - Load condition: track mode loads when sync[last]=1; capture mode loads when sync[last]=1 and vq=0.
  - Latency: code_valid rising before edge 0 gives sync[last]=1 after edge S-1. The load happens at edge S, so outputs show sm codes after edge S (edge 2 at defaults).
  - When the load condition is false, codes hold.
  - freeze=1: codes hold and no upd_pulse is generated, even if ovr_en or the load condition is true. A capture-mode edge that arrives during freeze is lost.
  - ovr_en=1 with freeze=0: every channel loads ovr_grey/ovr_igray, overriding sm codes and valid.
- upd_pulse[c]: registered; 1 for exactly one cycle after any non-scan edge where grey_c or igray_c changed value. Reloading an identical code gives no pulse.
- Simultaneous events:
  - ovr_en and a valid load in the same cycle: the override wins.
  - RST with SE: RST wins.
- Scan preserves no functional state. Dropping SE resumes functional operation from the shifted-in contents, and the first post-scan edge produces no upd_pulse for scanned-in differences.

Test Plan:
- Reset: drive RST=1 for one edge with arbitrary prior state -> all outputs 0 the next cycle; RST=0 with code_valid=0 -> codes stay 0.
- Track latency: ch0 sm_grey=7'h2A, sm_igray=3'h5, code_valid[0] rises -> grey[6:0]=2A, igray[2:0]=5 after edge 2; upd_pulse[0]=1 after edge 3 only. Then change sm_grey to 7'h2B while valid is held -> follows one edge later, with a new pulse.
- Capture mode: code_valid[1] held high while sm_grey changes 0x10->0x11->0x12 -> ch1 latches only the value present at the load edge. Later changes are ignored until valid drops for at least 2 cycles and rises again.
- Override/freeze: ovr_en=1, ovr_grey=7'h7F, ovr_igray=3'h7 -> both channels show 7F/7 and both pulse. Then assert freeze and ovr_en with new values -> outputs hold, no pulse.
- Scan: SE=1, shift a 26-bit pattern 0x2AAAAAA in -> SO_OUT reproduces it after 26 further shifts; upd_pulse stays 0 throughout.
- RST asserted mid-shift and mid-capture -> all state 0 next edge, in both cases.
